dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder: the target end of the load/store port that the pipeline's MEM stage drives.
- Accepts one 8-bit read or write request at a time through a valid/ready handshake and inserts a configurable number of wait states.
- Returns a response (read data or write acknowledge, plus an error flag) through a second valid/ready handshake.
- Sits between the pipeline's MEM stage and the data-memory array. Its `busy` output feeds the hazard/stall logic.

Parameters:
- WAIT_CYCLES, 2, wait states between request accept and array commit (0..15).
- DEPTH, 256, number of implemented bytes; addresses >= DEPTH are out of range.
- ADDR_W, 8, request address width.
- DATA_W, 8, data width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  initiator accepts the response.
- rsp_rdata  out  DATA_W  load data; 0 for stores and errors.
- rsp_err  out  1  out-of-range access.
- busy  out  1  transaction in flight (state != IDLE).

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE, wait counter = 0, latched request registers cleared.
  - req_ready = 1 after reset release; rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, busy = 0.
  - Array contents are not cleared.
  - Reset mid-transaction aborts it; a store not yet committed is never written.
- Three-state FSM: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - Accept on a rising edge with req_valid & req_ready: latch write, addr, wdata.
  - If WAIT_CYCLES = 0, commit on the accept edge and enter RESP. Otherwise load counter = WAIT_CYCLES-1 and enter WAIT.
- WAIT:
  - req_ready = 0.
  - Counter decrements each edge. On the edge where the counter is 0, commit and enter RESP.
- Commit (single edge):
  - Out-of-range address: no array access; rsp_err <= 1, rsp_rdata <= 0.
  - In-range store: array[addr] <= wdata; rsp_rdata <= 0.
  - In-range load: rsp_rdata <= array[addr].
- RESP:
  - rsp_valid = 1; rsp_rdata and rsp_err are held stable until the response handshake.
  - On rsp_valid & rsp_ready: return to IDLE; rsp_valid, rsp_rdata and rsp_err clear on that edge.
  - No request is accepted in RESP (req_ready = 0). No back-to-back overlap.
- Latency: rsp_valid rises WAIT_CYCLES+1 edges after the accept edge.
- Throughput: one transaction per WAIT_CYCLES+2 cycles minimum, when rsp_ready is held high.
- req_* inputs are ignored while not in IDLE; changes after accept have no effect.
- A load from an address written by the previous transaction returns the new value, because the commit precedes the next accept.
- Address compare uses the full ADDR_W bits. For DEPTH = 2^ADDR_W, rsp_err is never asserted.
- busy = (state != IDLE); purely combinational from state.

Decomposition:
- Shared package (pipeline-wide memory constants): FSM state encoding constants IDLE=2'd0, WAIT=2'd1, RESP=2'd2; default DATA_W/ADDR_W.
- One sub-module: dmem_array. It is a synchronous single-port byte array with write enable, address, write data and read data registered on the commit edge, has no reset, and is sized by DEPTH.
- The FSM, counter and range check live in dmem_responder.

Test Plan:
- Reset then idle: assert rst low mid-WAIT of a store to 0x10 with data 0x5A, release -> req_ready=1, rsp_valid=0, busy=0; a later load of 0x10 returns the prior contents, not 0x5A.
- Store/load, WAIT_CYCLES=2: store 0xA5 to 0x3C, rsp_ready=1 -> rsp_valid high exactly 3 edges after accept, rsp_rdata=0, rsp_err=0; then load 0x3C -> rsp_rdata=0xA5.
- Response backpressure: load 0x07 (contents 0x11) with rsp_ready=0 for 5 cycles -> rsp_valid, rsp_rdata=0x11 held stable; req_ready=0 and busy=1 throughout; clears one edge after rsp_ready=1.
- Input change after accept: accept load 0x20, then drive req_addr=0x21 and req_valid=1 during WAIT -> response carries array[0x20]; the second request is accepted only after returning to IDLE.
- Out of range, DEPTH=64: store 0xFF to 0x40 -> rsp_err=1, rsp_rdata=0; array[0x00] unchanged. Load 0x3F -> rsp_err=0.
- WAIT_CYCLES=0: continuous alternating store/load to 0x01 with rsp_ready=1 -> rsp_valid 1 edge after each accept; one transaction every 2 cycles; load returns the just-stored value.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Memory constants shared by the pipeline's data-memory path: bus widths and the
// responder FSM state encoding.
package dmem_responder_pkg;

  localparam int DMEM_ADDR_W = 8;
  localparam int DMEM_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

endpackage

// File: rtl/dmem_array.sv
// Synchronous single-port byte array, no reset; read data is registered on an enabled read edge.
// One-edge access latency; no flow control, the owner issues at most one access per edge.
module dmem_array #(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 8,
  parameter int IDX_W  = 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Load/store target for the MEM stage: one request at a time, WAIT_CYCLES wait states, then a response.
// Response held until rsp_ready; req_ready is low (busy high) from accept until the response handshake.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int DEPTH       = 256,
  parameter int ADDR_W      = DMEM_ADDR_W,
  parameter int DATA_W      = DMEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int              IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]      CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
  localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W + 1)'(DEPTH);

  dmem_state_t       state, state_nxt;
  logic [3:0]        cnt;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              rd_ok;
  logic              err_q;
  logic              accept, commit;
  logic              c_write, c_in_range;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata, arr_rdata;

  assign accept = (state == IDLE) && req_valid;

  // Zero wait states commit straight from the request inputs on the accept edge.
  assign c_write    = (state == IDLE) ? req_write : wr_q;
  assign c_addr     = (state == IDLE) ? req_addr  : addr_q;
  assign c_wdata    = (state == IDLE) ? req_wdata : wdata_q;
  assign c_in_range = ({1'b0, c_addr} < DEPTH_L);

  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (WAIT_CYCLES == 0) begin
            commit    = 1'b1;
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          commit    = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= 4'd0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_ok   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        wr_q    <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        cnt     <= CNT_INIT;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (commit) begin
        err_q <= !c_in_range;
        rd_ok <= c_in_range && !c_write;
      end else if (state == RESP && rsp_ready) begin
        err_q <= 1'b0;
        rd_ok <= 1'b0;
      end
    end
  end

  dmem_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clk),
    .en    (commit && c_in_range),
    .we    (c_write),
    .addr  (c_addr[IDX_W-1:0]),
    .wdata (c_wdata),
    .rdata (arr_rdata)
  );

  // Array read data has no reset, so it is only exposed for a committed in-range load.
  assign rsp_rdata = rd_ok ? arr_rdata : '0;
  assign rsp_err   = err_q;
  assign rsp_valid = (state == RESP);
  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: instance 0 has 2 wait states and 64 bytes, instance 1 has 0 wait states and 256 bytes.
module tb_dmem_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_valid [2];
  logic       req_write [2];
  logic [7:0] req_addr  [2];
  logic [7:0] req_wdata [2];
  logic       rsp_ready [2];
  logic       req_ready [2];
  logic       rsp_valid [2];
  logic [7:0] rsp_rdata [2];
  logic       rsp_err   [2];
  logic       busy      [2];

  int         checks = 0;
  int         errors = 0;
  int         ecount = 0;
  logic [8:0] exp_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) ecount <= ecount + 1;

  dmem_responder #(.WAIT_CYCLES(2), .DEPTH(64), .ADDR_W(8), .DATA_W(8)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0]), .busy(busy[0])
  );

  dmem_responder #(.WAIT_CYCLES(0), .DEPTH(256), .ADDR_W(8), .DATA_W(8)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1]), .busy(busy[1])
  );

  task automatic wait_rsp(input int d, output bit to);
    for (int i = 0; i < 50 && !rsp_valid[d]; i++) @(negedge clk);
    to = !rsp_valid[d];
  endtask

  // Full transaction; lat counts edges from the accept edge (inclusive) to the rsp_valid rise.
  task automatic txn(input int d, input logic w, input logic [7:0] a, input logic [7:0] wd,
                     output logic [7:0] rd, output logic er, output int lat, output bit to);
    int acc;
    rd = '0; er = 1'b0; lat = 0; to = 1'b0;
    @(negedge clk);
    req_valid[d] = 1'b1; req_write[d] = w; req_addr[d] = a; req_wdata[d] = wd;
    for (int i = 0; i < 50 && !req_ready[d]; i++) @(negedge clk);
    if (!req_ready[d]) begin
      to = 1'b1; req_valid[d] = 1'b0;
      return;
    end
    acc = ecount + 1;
    @(negedge clk);
    req_valid[d] = 1'b0;
    wait_rsp(d, to);
    if (to) return;
    lat = ecount - acc + 1;
    rd = rsp_rdata[d]; er = rsp_err[d];
    rsp_ready[d] = 1'b1;
    @(negedge clk);
    rsp_ready[d] = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] rd; logic er; int lat; bit to; logic [8:0] e;
    repeat (3) @(negedge clk);
    checks++;
    if ({rsp_valid[0], busy[0], rsp_err[0], rsp_rdata[0]} !== 11'd0) begin
      errors++;
      $display("FAIL reset_hold: valid=%0b busy=%0b err=%0b rdata=%h, want all 0",
               rsp_valid[0], busy[0], rsp_err[0], rsp_rdata[0]);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({req_ready[0], req_ready[1], busy[1]} !== 3'b110) begin
      errors++;
      $display("FAIL reset_release: ready0=%0b ready1=%0b busy1=%0b, want 1 1 0", req_ready[0], req_ready[1], busy[1]);
    end
    exp_q.push_back({1'b0, 8'h00});
    txn(0, 1'b1, 8'h10, 8'h33, rd, er, lat, to);
    e = exp_q.pop_front();
    checks++;
    if (to || {er, rd} !== e) begin
      errors++;
      $display("FAIL reset_prestore: err=%0b rdata=%h timeout=%0b, want err=%0b rdata=%h", er, rd, to, e[8], e[7:0]);
    end
    @(negedge clk);
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 8'h10; req_wdata[0] = 8'h5A;
    @(negedge clk);
    req_valid[0] = 1'b0;
    checks++;
    if (busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL reset_inflight: busy=%0b, want 1", busy[0]);
    end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if ({req_ready[0], rsp_valid[0], busy[0], rsp_err[0], rsp_rdata[0]} !== {1'b1, 11'd0}) begin
      errors++;
      $display("FAIL reset_abort: ready=%0b valid=%0b busy=%0b err=%0b rdata=%h, want 1 0 0 0 00",
               req_ready[0], rsp_valid[0], busy[0], rsp_err[0], rsp_rdata[0]);
    end
    exp_q.push_back({1'b0, 8'h33});
    txn(0, 1'b0, 8'h10, 8'h00, rd, er, lat, to);
    e = exp_q.pop_front();
    checks++;
    if (to || {er, rd} !== e) begin
      errors++;
      $display("FAIL reset_no_commit: err=%0b rdata=%h timeout=%0b, want err=%0b rdata=%h", er, rd, to, e[8], e[7:0]);
    end
  endtask

  // Table-driven transactions on instance 0: store/load, then out-of-range behaviour at DEPTH=64.
  task automatic test_store_load_range();
    logic       tw [9] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [7:0] ta [9] = '{8'h3C, 8'h3C, 8'h00, 8'h3F, 8'h40, 8'h00, 8'h3F, 8'h40, 8'hFF};
    logic [7:0] td [9] = '{8'hA5, 8'h00, 8'h42, 8'h9C, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [8:0] te [9] = '{9'h000, 9'h0A5, 9'h000, 9'h000, 9'h100, 9'h042, 9'h09C, 9'h100, 9'h100};
    logic [7:0] rd; logic er; int lat; bit to; logic [8:0] e;
    for (int k = 0; k < 9; k++) begin
      exp_q.push_back(te[k]);
      txn(0, tw[k], ta[k], td[k], rd, er, lat, to);
      e = exp_q.pop_front();
      checks++;
      if (to || {er, rd} !== e) begin
        errors++;
        $display("FAIL txn%0d addr=%h: err=%0b rdata=%h timeout=%0b, want err=%0b rdata=%h",
                 k, ta[k], er, rd, to, e[8], e[7:0]);
      end
      checks++;
      if (lat !== 3) begin
        errors++;
        $display("FAIL latency%0d: %0d edges, want 3", k, lat);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] rd; logic er; int lat; bit to; logic [8:0] e;
    exp_q.push_back({1'b0, 8'h00});
    txn(0, 1'b1, 8'h07, 8'h11, rd, er, lat, to);
    e = exp_q.pop_front();
    checks++;
    if (to || {er, rd} !== e) begin
      errors++;
      $display("FAIL bp_store: err=%0b rdata=%h timeout=%0b, want err=%0b rdata=%h", er, rd, to, e[8], e[7:0]);
    end
    @(negedge clk);
    req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 8'h07;
    exp_q.push_back({1'b0, 8'h11});
    @(negedge clk);
    req_valid[0] = 1'b0;
    wait_rsp(0, to);
    e = exp_q.pop_front();
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (to || {rsp_valid[0], rsp_err[0], rsp_rdata[0], req_ready[0], busy[0]} !== {1'b1, e, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL bp_hold%0d: valid=%0b err=%0b rdata=%h ready=%0b busy=%0b, want 1 %0b %h 0 1",
                 c, rsp_valid[0], rsp_err[0], rsp_rdata[0], req_ready[0], busy[0], e[8], e[7:0]);
      end
      @(negedge clk);
    end
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    rsp_ready[0] = 1'b0;
    checks++;
    if ({rsp_valid[0], rsp_err[0], rsp_rdata[0], busy[0], req_ready[0]} !== 12'b0_0_00000000_0_1) begin
      errors++;
      $display("FAIL bp_release: valid=%0b err=%0b rdata=%h busy=%0b ready=%0b, want 0 0 00 0 1",
               rsp_valid[0], rsp_err[0], rsp_rdata[0], busy[0], req_ready[0]);
    end
  endtask

  task automatic test_input_change();
    logic [7:0] rd; logic er; int lat; bit to, to2; logic [8:0] e;
    txn(0, 1'b1, 8'h20, 8'h77, rd, er, lat, to);
    txn(0, 1'b1, 8'h21, 8'h88, rd, er, lat, to2);
    checks++;
    if (to || to2) begin
      errors++;
      $display("FAIL ic_preload: timeout=%0b/%0b, want 0/0", to, to2);
    end
    @(negedge clk);
    req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 8'h20;
    exp_q.push_back({1'b0, 8'h77});
    exp_q.push_back({1'b0, 8'h88});
    @(negedge clk);
    req_addr[0] = 8'h21;
    wait_rsp(0, to);
    e = exp_q.pop_front();
    checks++;
    if (to || {rsp_err[0], rsp_rdata[0], req_ready[0]} !== {e, 1'b0}) begin
      errors++;
      $display("FAIL ic_first: err=%0b rdata=%h ready=%0b timeout=%0b, want err=%0b rdata=%h ready=0",
               rsp_err[0], rsp_rdata[0], req_ready[0], to, e[8], e[7:0]);
    end
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    rsp_ready[0] = 1'b0;
    checks++;
    if ({req_ready[0], busy[0], rsp_valid[0]} !== 3'b100) begin
      errors++;
      $display("FAIL ic_idle: ready=%0b busy=%0b valid=%0b, want 1 0 0", req_ready[0], busy[0], rsp_valid[0]);
    end
    @(negedge clk);
    req_valid[0] = 1'b0;
    checks++;
    if (busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL ic_second_accept: busy=%0b, want 1", busy[0]);
    end
    wait_rsp(0, to);
    e = exp_q.pop_front();
    checks++;
    if (to || {rsp_err[0], rsp_rdata[0]} !== e) begin
      errors++;
      $display("FAIL ic_second: err=%0b rdata=%h timeout=%0b, want err=%0b rdata=%h",
               rsp_err[0], rsp_rdata[0], to, e[8], e[7:0]);
    end
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    rsp_ready[0] = 1'b0;
  endtask

  // Instance 1, zero wait states, rsp_ready held high, requests offered whenever req_ready is seen.
  task automatic test_zero_wait();
    int nxt = 0, done = 0, last = -1, a;
    int acc_q [$];
    logic [8:0] e;
    rsp_ready[1] = 1'b1;
    for (int c = 0; c < 60 && done < 8; c++) begin
      @(negedge clk);
      if (rsp_valid[1]) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL zw_spurious: unexpected response rdata=%h", rsp_rdata[1]);
        end else begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          if ({rsp_err[1], rsp_rdata[1]} !== e) begin
            errors++;
            $display("FAIL zw_data%0d: err=%0b rdata=%h, want err=%0b rdata=%h", done, rsp_err[1], rsp_rdata[1], e[8], e[7:0]);
          end
          checks++;
          if (ecount - a + 1 !== 1) begin
            errors++;
            $display("FAIL zw_latency%0d: %0d edges, want 1", done, ecount - a + 1);
          end
        end
        if (last >= 0) begin
          checks++;
          if (ecount - last !== 2) begin
            errors++;
            $display("FAIL zw_spacing%0d: %0d cycles, want 2", done, ecount - last);
          end
        end
        last = ecount;
        done++;
      end
      if (req_ready[1] && nxt < 8) begin
        req_valid[1] = 1'b1; req_write[1] = (nxt % 2 == 0); req_addr[1] = 8'h01;
        req_wdata[1] = 8'(8'h30 + nxt);
        exp_q.push_back((nxt % 2 == 0) ? 9'h000 : {1'b0, 8'(8'h30 + nxt - 1)});
        acc_q.push_back(ecount + 1);
        nxt++;
      end else begin
        req_valid[1] = 1'b0;
      end
    end
    req_valid[1] = 1'b0;
    rsp_ready[1] = 1'b0;
    checks++;
    if (done !== 8) begin
      errors++;
      $display("FAIL zw_count: %0d responses, want 8", done);
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_write[d] = 1'b0; req_addr[d] = '0; req_wdata[d] = '0; rsp_ready[d] = 1'b0;
    end
    test_reset();
    test_store_load_range();
    test_backpressure();
    test_input_change();
    test_zero_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
